alu_op_issuer: RTL

- Initiator side of the ALU operand/result interface.
- Accepts operation requests on a valid/ready stream and drives the ALU input pins (CE, MODE, CMD, OPA, OPB, CIN, INP_VALID).
- Waits the command-dependent ALU latency, captures RES and flags, and returns them on a response stream.
- Sits between a command source (CPU bridge or test sequencer) and the ALU design.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_lat_sel.sv | 23 ++
 rtl/alu_op_issuer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand/result issuer.
package alu_pkg;

   // Default data-path widths; the issuer's WIDTH/CMD_W parameters must match these.
   localparam int ALU_WIDTH = 8;
   localparam int ALU_CMD_W = 4;
   localparam int LAT_W     = 4;

   // Multiply commands (arithmetic mode) take the longer ALU latency.
   localparam int CMD_MUL_INC = 9;
   localparam int CMD_MUL_SHL = 10;

   // Operand-valid codes.
   localparam logic [1:0] INPV_NONE = 2'b00;
   localparam logic [1:0] INPV_BOTH = 2'b11;

   // Bit positions inside the 6-bit {COUT,OFLOW,G,L,E,ERR} flag vector.
   localparam int FLAG_ERR   = 0;
   localparam int FLAG_E     = 1;
   localparam int FLAG_L     = 2;
   localparam int FLAG_G     = 3;
   localparam int FLAG_OFLOW = 4;
   localparam int FLAG_COUT  = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CAPTURE,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic                 mode;
      logic [ALU_CMD_W-1:0] cmd;
      logic [ALU_WIDTH-1:0] opa;
      logic [ALU_WIDTH-1:0] opb;
      logic                 cin;
      logic [1:0]           inp_valid;
   } alu_req_t;

   typedef struct packed {
      logic [2*ALU_WIDTH-1:0] res;
      logic [5:0]             flags;
      logic                   skip;
   } alu_rsp_t;

   // A request with no valid operand never reaches the ALU.
   function automatic logic is_skip(input logic [1:0] inp_valid);
      return inp_valid == INPV_NONE;
   endfunction

endpackage

// File: rtl/alu_lat_sel.sv
// Maps {mode, cmd} to the ALU latency in cycles.
module alu_lat_sel
   import alu_pkg::*;
#(
   parameter int CMD_W    = 4,
   parameter int LAT_NORM = 1,
   parameter int LAT_MUL  = 2
) (
   input  logic             mode,
   input  logic [CMD_W-1:0] cmd,
   output logic [LAT_W-1:0] lat
);

   // Multiply commands in arithmetic mode use the long latency.
   always_comb begin
      if (mode && (cmd == CMD_W'(CMD_MUL_INC) || cmd == CMD_W'(CMD_MUL_SHL))) begin
         lat = LAT_W'(LAT_MUL);
      end else begin
         lat = LAT_W'(LAT_NORM);
      end
   end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one ALU operation at a time from a request stream and returns the
// captured result on a response stream.
//
// Handshakes: a transfer happens on a rising CLK edge where valid && ready are
// both high; the sender holds its payload stable while valid is high and
// ready is low. req_ready is high only in IDLE; rsp_valid holds until taken.
module alu_op_issuer
   import alu_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CMD_W    = 4,
   parameter int LAT_NORM = 1,
   parameter int LAT_MUL  = 2,
   parameter int CNT_W    = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_mode,
   input  logic [CMD_W-1:0]   req_cmd,
   input  logic [WIDTH-1:0]   req_opa,
   input  logic [WIDTH-1:0]   req_opb,
   input  logic               req_cin,
   input  logic [1:0]         req_inp_valid,
   output logic               alu_ce,
   output logic               alu_mode,
   output logic [CMD_W-1:0]   alu_cmd,
   output logic [WIDTH-1:0]   alu_opa,
   output logic [WIDTH-1:0]   alu_opb,
   output logic               alu_cin,
   output logic [1:0]         alu_inp_valid,
   input  logic [2*WIDTH-1:0] alu_res,
   input  logic [5:0]         alu_flags,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2*WIDTH-1:0] rsp_res,
   output logic [5:0]         rsp_flags,
   output logic               rsp_skip,
   output logic               busy,
   output logic [CNT_W-1:0]   ops_issued,
   output logic [CNT_W-1:0]   err_count
);

   state_e             state_q, state_d;
   alu_req_t           req_q, req_d;
   alu_req_t           alu_q, alu_d;
   alu_rsp_t           rsp_q, rsp_d;
   logic [LAT_W-1:0]   cnt_q, cnt_d;
   logic               req_ready_q, req_ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               alu_ce_q, alu_ce_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   ops_q, ops_d;
   logic [CNT_W-1:0]   err_q, err_d;
   logic [LAT_W-1:0]   lat;
   logic               req_fire;

   alu_lat_sel #(
      .CMD_W    (CMD_W),
      .LAT_NORM (LAT_NORM),
      .LAT_MUL  (LAT_MUL)
   ) u_lat_sel (
      .mode (req_q.mode),
      .cmd  (req_q.cmd),
      .lat  (lat)
   );

   assign req_fire = req_valid && req_ready_q;

   // Next-state and next-output logic for the issue/wait/capture/respond sequence.
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      alu_d       = alu_q;
      rsp_d       = rsp_q;
      cnt_d       = cnt_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      alu_ce_d    = alu_ce_q;
      ops_d       = ops_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (req_fire) begin
               req_d       = '{mode: req_mode, cmd: req_cmd, opa: req_opa, opb: req_opb,
                               cin: req_cin, inp_valid: req_inp_valid};
               req_ready_d = 1'b0;
               // A skipped request goes straight to CAPTURE, which loads the
               // empty response without touching the ALU.
               state_d     = is_skip(req_inp_valid) ? ST_CAPTURE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            alu_d    = req_q;
            alu_ce_d = 1'b1;
            cnt_d    = lat;
            ops_d    = ops_q + 1'b1;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q <= LAT_W'(1)) begin
               state_d = ST_CAPTURE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (is_skip(req_q.inp_valid)) begin
               rsp_d = '{res: '0, flags: '0, skip: 1'b1};
            end else begin
               rsp_d = '{res: alu_res, flags: alu_flags, skip: 1'b0};
            end
            alu_ce_d        = 1'b0;
            alu_d.inp_valid = INPV_NONE;
            rsp_valid_d     = 1'b1;
            state_d         = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (rsp_q.flags[FLAG_ERR] || rsp_q.skip) begin
                  err_d = err_q + 1'b1;
               end
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; synchronous active-low reset clears everything.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         alu_q       <= '0;
         rsp_q       <= '0;
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         alu_ce_q    <= 1'b0;
         busy_q      <= 1'b0;
         ops_q       <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         alu_q       <= alu_d;
         rsp_q       <= rsp_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         alu_ce_q    <= alu_ce_d;
         busy_q      <= busy_d;
         ops_q       <= ops_d;
         err_q       <= err_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign alu_ce        = alu_ce_q;
   assign alu_mode      = alu_q.mode;
   assign alu_cmd       = alu_q.cmd;
   assign alu_opa       = alu_q.opa;
   assign alu_opb       = alu_q.opb;
   assign alu_cin       = alu_q.cin;
   assign alu_inp_valid = alu_q.inp_valid;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_res       = rsp_q.res;
   assign rsp_flags     = rsp_q.flags;
   assign rsp_skip      = rsp_q.skip;
   assign busy          = busy_q;
   assign ops_issued    = ops_q;
   assign err_count     = err_q;

endmodule
